// File: rtl/win_scanner_if.sv
// Handshake and result bundle between board storage/turn control and win_scanner.
//   start       : scan request (controller -> scanner)
//   board_state : 2 bits per cell, cell k at [2k+1:2k] (controller -> scanner)
//   busy, done  : scan in progress / one-cycle result-valid pulse (scanner -> controller)
//   black_win, white_win, win_pos, win_dir : registered scan result (scanner -> controller)
interface win_scanner_if #(
    parameter int unsigned N = 10
);
    localparam int unsigned CELLS = N * N;
    localparam int unsigned POS_W = $clog2(CELLS);

    logic                 start;
    logic [2*CELLS-1:0]   board_state;
    logic                 busy;
    logic                 done;
    logic                 black_win;
    logic                 white_win;
    logic [POS_W-1:0]     win_pos;
    logic [1:0]           win_dir;

    modport master (
        output start, board_state,
        input  busy, done, black_win, white_win, win_pos, win_dir
    );

    modport slave (
        input  start, board_state,
        output busy, done, black_win, white_win, win_pos, win_dir
    );
endinterface

// File: rtl/win_scanner.sv
// Sequential Gomoku win detector: snapshots the board on start, tests one cell per
// clock in four directions and reports the first run found (lowest cell, then
// lowest direction code).
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : win_scanner_if slave (start/board_state in, busy/done/results out)
module win_scanner #(
    parameter int unsigned N       = 10,
    parameter int unsigned WIN_LEN = 5,
    parameter int unsigned EXACT   = 0
) (
    input  logic          clk,
    input  logic          rst,
    win_scanner_if.slave  bus
);
    localparam int unsigned CELLS = N * N;
    localparam int unsigned POS_W = $clog2(CELLS);
    localparam int unsigned RC_W  = $clog2(N);
    localparam int unsigned BIT_W = $clog2(2 * CELLS);
    localparam int          NS    = int'(N);
    localparam int          WL    = int'(WIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   k_q, k_d;
    logic [RC_W-1:0]    row_q, row_d;
    logic [RC_W-1:0]    col_q, col_d;
    logic [2*CELLS-1:0] snap_q;
    logic               load;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bw_q, bw_d;
    logic               ww_q, ww_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [1:0]         dir_q, dir_d;
    logic [3:0]         match_b, match_w;
    logic               hit;
    logic [1:0]         hit_dir;

    // Cell contents at (r, c); anything off-board reads as empty.
    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int r, input int c);
        logic [1:0] v;
        v = 2'b00;
        if (r >= 0 && r < NS && c >= 0 && c < NS)
            v = b[BIT_W'(2 * (r * NS + c)) +: 2];
        return v;
    endfunction

    // Four-direction run test for the current cell.
    always_comb begin : p_match
        int         r, c, dr, dc, er, ec;
        logic [1:0] cl, pre, post;
        logic       ab, aw;
        match_b = '0;
        match_w = '0;
        r    = int'(row_q);
        c    = int'(col_q);
        dr   = 0;
        dc   = 0;
        er   = 0;
        ec   = 0;
        cl   = 2'b00;
        pre  = 2'b00;
        post = 2'b00;
        ab   = 1'b0;
        aw   = 1'b0;
        for (int d = 0; d < 4; d++) begin
            dr = (d == 0) ? 0 : 1;
            dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
            er = r + (WL - 1) * dr;
            ec = c + (WL - 1) * dc;
            ab = (er >= 0 && er < NS && ec >= 0 && ec < NS);
            aw = ab;
            for (int i = 0; i < WL; i++) begin
                cl = cell_at(snap_q, r + i * dr, c + i * dc);
                ab = ab & (cl == 2'b10);
                aw = aw & (cl == 2'b11);
            end
            // Overline rejection: neighbours on either end must not extend the run.
            if (EXACT != 0) begin
                pre  = cell_at(snap_q, r - dr, c - dc);
                post = cell_at(snap_q, er + dr, ec + dc);
                if (pre == 2'b10 || post == 2'b10) ab = 1'b0;
                if (pre == 2'b11 || post == 2'b11) aw = 1'b0;
            end
            match_b[2'(d)] = ab;
            match_w[2'(d)] = aw;
        end
    end

    // Lowest matching direction code, regardless of colour.
    always_comb begin
        hit     = |(match_b | match_w);
        hit_dir = 2'd0;
        for (int d = 3; d >= 0; d--) begin
            if (match_b[2'(d)] | match_w[2'(d)]) hit_dir = 2'(d);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        bw_d    = bw_q;
        ww_d    = ww_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = S_SCAN;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    bw_d    = 1'b0;
                    ww_d    = 1'b0;
                    pos_d   = '0;
                    dir_d   = 2'd0;
                end
            end
            S_SCAN: begin
                if (hit) begin
                    state_d = S_DONE;
                    bw_d    = |match_b;
                    ww_d    = |match_w;
                    pos_d   = k_q;
                    dir_d   = hit_dir;
                end else if (k_q == POS_W'(CELLS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + POS_W'(1);
                    if (col_q == RC_W'(N - 1)) begin
                        col_d = '0;
                        row_d = row_q + RC_W'(1);
                    end else begin
                        col_d = col_q + RC_W'(1);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bw_q    <= 1'b0;
            ww_q    <= 1'b0;
            pos_q   <= '0;
            dir_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bw_q    <= bw_d;
            ww_q    <= ww_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
        end
    end

    // Board snapshot; contents are irrelevant until the next accepted start.
    always_ff @(posedge clk) begin
        if (load) snap_q <= bus.board_state;
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.black_win = bw_q;
    assign bus.white_win = ww_q;
    assign bus.win_pos   = pos_q;
    assign bus.win_dir   = dir_q;
endmodule

// File: tb/tb_win_scanner.sv
// Self-checking bench for win_scanner: one instance with EXACT=0 and one with
// EXACT=1 share clock, reset and stimulus.
module tb_win_scanner;
    localparam int          N     = 10;
    localparam int          WIN   = 5;
    localparam int          CELLS = N * N;
    localparam int unsigned BI    = $clog2(2 * CELLS);

    typedef logic [2*CELLS-1:0] board_t;
    typedef struct {
        logic b;
        logic w;
        int   pos;
        int   dir;
        int   lat;
        int   pulses;
    } res_t;
    typedef struct {
        string  name;
        board_t board;
        res_t   e0;
        res_t   e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    win_scanner_if #(.N(N)) bus0 ();
    win_scanner_if #(.N(N)) bus1 ();

    win_scanner #(.N(N), .WIN_LEN(WIN), .EXACT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    win_scanner #(.N(N), .WIN_LEN(WIN), .EXACT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic res_t mk(input bit b, input bit w, input int pos, input int dir, input int lat);
        res_t r;
        r.b = b; r.w = w; r.pos = pos; r.dir = dir; r.lat = lat; r.pulses = 1;
        return r;
    endfunction

    function automatic board_t stones(input board_t base, input int first, input int step,
                                      input int cnt, input logic [1:0] v);
        for (int i = 0; i < cnt; i++) base[BI'(2 * (first + i * step)) +: 2] = v;
        return base;
    endfunction

    // Reference: a run starting at k is the maximal same-colour stretch measured
    // forward from k; exact mode additionally requires k to start that stretch.
    function automatic res_t model(input board_t bd, input bit exact);
        int         g[N][N];
        int         dr[4] = '{0, 1, 1, 1};
        int         dc[4] = '{1, 0, 1, -1};
        logic [1:0] cv;
        res_t       res;
        bit         found;
        res = mk(0, 0, 0, 0, CELLS);
        for (int k = 0; k < CELLS; k++) begin
            cv = bd[BI'(2 * k) +: 2];
            g[k / N][k % N] = cv[1] ? (cv[0] ? 2 : 1) : 0;
        end
        for (int k = 0; k < CELLS; k++) begin
            int r, c, s;
            r = k / N; c = k % N; s = g[r][c];
            found = 0;
            if (s != 0) begin
                for (int d = 0; d < 4; d++) begin
                    int  len, rr, cc, pr, pc;
                    bit  prev_same, h;
                    len = 0; rr = r; cc = c;
                    while (rr >= 0 && rr < N && cc >= 0 && cc < N && g[rr][cc] == s) begin
                        len++; rr += dr[d]; cc += dc[d];
                    end
                    pr = r - dr[d]; pc = c - dc[d];
                    prev_same = (pr >= 0 && pr < N && pc >= 0 && pc < N && g[pr][pc] == s);
                    h = exact ? (!prev_same && len == WIN) : (len >= WIN);
                    if (h) begin
                        if (!found) begin res.pos = k; res.dir = d; end
                        found = 1;
                        if (s == 1) res.b = 1; else res.w = 1;
                    end
                end
            end
            if (found) begin
                res.lat = k + 1;
                return res;
            end
        end
        return res;
    endfunction

    task automatic chk_zero(input string name);
        chk({name, "/busy0"}, 32'(bus0.busy), 0);
        chk({name, "/done0"}, 32'(bus0.done), 0);
        chk({name, "/bw0"},   32'(bus0.black_win), 0);
        chk({name, "/ww0"},   32'(bus0.white_win), 0);
        chk({name, "/pos0"},  32'(bus0.win_pos), 0);
        chk({name, "/dir0"},  32'(bus0.win_dir), 0);
        chk({name, "/busy1"}, 32'(bus1.busy), 0);
        chk({name, "/done1"}, 32'(bus1.done), 0);
        chk({name, "/bw1"},   32'(bus1.black_win), 0);
        chk({name, "/ww1"},   32'(bus1.white_win), 0);
        chk({name, "/pos1"},  32'(bus1.win_pos), 0);
        chk({name, "/dir1"},  32'(bus1.win_dir), 0);
    endtask

    task automatic launch(input board_t b);
        @(negedge clk);
        bus0.board_state = b; bus1.board_state = b;
        bus0.start = 1'b1;    bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;    bus1.start = 1'b0;
    endtask

    // Watch both instances for a bounded number of cycles after the start edge;
    // optionally poke board_state/start once mid-scan.
    task automatic wait_done(input int poke_at, input board_t pb, input bit ps,
                             output res_t g0, output res_t g1);
        g0 = '{1'b0, 1'b0, 0, 0, -1, 0};
        g1 = '{1'b0, 1'b0, 0, 0, -1, 0};
        for (int cyc = 1; cyc <= CELLS + 3; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == poke_at) begin
                bus0.board_state = pb; bus1.board_state = pb;
                bus0.start = ps;       bus1.start = ps;
            end else begin
                bus0.start = 1'b0;     bus1.start = 1'b0;
            end
            if (bus0.done) begin
                g0.pulses++;
                if (g0.lat < 0) begin
                    g0.lat = cyc; g0.b = bus0.black_win; g0.w = bus0.white_win;
                    g0.pos = int'(bus0.win_pos); g0.dir = int'(bus0.win_dir);
                end
            end
            if (bus1.done) begin
                g1.pulses++;
                if (g1.lat < 0) begin
                    g1.lat = cyc; g1.b = bus1.black_win; g1.w = bus1.white_win;
                    g1.pos = int'(bus1.win_pos); g1.dir = int'(bus1.win_dir);
                end
            end
        end
    endtask

    task automatic cmp(input string name, input res_t g, input res_t e);
        chk({name, "/latency"}, g.lat, e.lat);
        chk({name, "/black"},   32'(g.b), 32'(e.b));
        chk({name, "/white"},   32'(g.w), 32'(e.w));
        chk({name, "/pos"},     g.pos, e.pos);
        chk({name, "/dir"},     g.dir, e.dir);
        chk({name, "/pulses"},  g.pulses, e.pulses);
    endtask

    task automatic run_vec(input string name, input board_t b, input res_t e0, input res_t e1,
                           input int poke_at, input board_t pb, input bit ps);
        res_t g0, g1;
        launch(b);
        chk({name, "/busy_up0"}, 32'(bus0.busy), 1);
        chk({name, "/busy_up1"}, 32'(bus1.busy), 1);
        chk({name, "/clr0"}, 32'({bus0.black_win, bus0.white_win}), 0);
        chk({name, "/clr1"}, 32'({bus1.black_win, bus1.white_win}), 0);
        wait_done(poke_at, pb, ps, g0, g1);
        cmp({name, "/x0"}, g0, e0);
        cmp({name, "/x1"}, g1, e1);
        // results must still hold once back in IDLE
        chk({name, "/idle0"}, 32'(bus0.busy), 0);
        chk({name, "/idle1"}, 32'(bus1.busy), 0);
        chk({name, "/hold_b0"}, 32'(bus0.black_win), 32'(e0.b));
        chk({name, "/hold_w1"}, 32'(bus1.white_win), 32'(e1.w));
        chk({name, "/hold_pos0"}, 32'(bus0.win_pos), e0.pos);
        chk({name, "/hold_dir1"}, 32'(bus1.win_dir), e1.dir);
    endtask

    initial begin
        vec_t   tbl[$];
        board_t z, rb;
        res_t   none;
        z    = '0;
        none = mk(0, 0, 0, 0, CELLS);

        rst = 1'b1;
        bus0.start = 1'b0; bus1.start = 1'b0;
        bus0.board_state = z; bus1.board_state = z;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back('{"blk_row0",   stones(z, 0, 1, 5, 2'b10),   mk(1, 0, 0, 0, 1),   mk(1, 0, 0, 0, 1)});
        tbl.push_back('{"wht_diag13", stones(z, 13, 11, 5, 2'b11), mk(0, 1, 13, 2, 14), mk(0, 1, 13, 2, 14)});
        tbl.push_back('{"blk_wrap",   stones(z, 8, 1, 5, 2'b10),   none,                none});
        tbl.push_back('{"blk_col9",   stones(z, 9, 10, 5, 2'b10),  mk(1, 0, 9, 1, 10),  mk(1, 0, 9, 1, 10)});
        tbl.push_back('{"blk_anti4",  stones(z, 4, 9, 5, 2'b10),   mk(1, 0, 4, 3, 5),   mk(1, 0, 4, 3, 5)});
        tbl.push_back('{"blk_six",    stones(z, 0, 1, 6, 2'b10),   mk(1, 0, 0, 0, 1),   none});
        tbl.push_back('{"blk_20_24",  stones(z, 20, 1, 5, 2'b10),  mk(1, 0, 20, 0, 21), mk(1, 0, 20, 0, 21)});
        tbl.push_back('{"wht_last",   stones(z, 95, 1, 5, 2'b11),  mk(0, 1, 95, 0, 96), mk(0, 1, 95, 0, 96)});
        tbl.push_back('{"blk_four",   stones(z, 0, 1, 4, 2'b10),   none,                none});
        foreach (tbl[i]) run_vec(tbl[i].name, tbl[i].board, tbl[i].e0, tbl[i].e1, 0, z, 1'b0);

        // start re-pulsed mid-scan with a different board: ignored
        run_vec("restart_ignored", stones(z, 95, 1, 5, 2'b11), mk(0, 1, 95, 0, 96), mk(0, 1, 95, 0, 96),
                10, stones(z, 0, 1, 5, 2'b10), 1'b1);
        // board cleared mid-scan: snapshot result still reported
        run_vec("board_cleared", stones(z, 95, 1, 5, 2'b11), mk(0, 1, 95, 0, 96), mk(0, 1, 95, 0, 96),
                50, z, 1'b0);

        // reset in IDLE clears held results
        run_vec("pre_rst", stones(z, 13, 11, 5, 2'b11), mk(0, 1, 13, 2, 14), mk(0, 1, 13, 2, 14), 0, z, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("rst_idle");
        @(negedge clk); rst = 1'b0;

        // reset mid-scan (around k=50)
        launch(z);
        repeat (49) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("rst_mid");
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst_mid_after");

        // reset and start on the same edge: stays IDLE
        @(negedge clk);
        rst = 1'b1;
        bus0.board_state = stones(z, 0, 1, 5, 2'b10); bus1.board_state = stones(z, 0, 1, 5, 2'b10);
        bus0.start = 1'b1; bus1.start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0; bus0.start = 1'b0; bus1.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_start");

        run_vec("post_rst", stones(z, 20, 1, 5, 2'b10), mk(1, 0, 20, 0, 21), mk(1, 0, 20, 0, 21), 0, z, 1'b0);

        // randomized boards against the reference model
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < CELLS; i++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                rb[BI'(2 * i) +: 2] = (sel < 2) ? 2'b00 : (sel < 4) ? 2'b01 : (sel < 7) ? 2'b10 : 2'b11;
            end
            run_vec($sformatf("rand%0d", n), rb, model(rb, 1'b0), model(rb, 1'b1), 0, z, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
